// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data memory.
// Data wins by default; a pending fetch is served after MAX_DSTREAK data grants, and stuck accesses abort after TIMEOUT cycles.
module memory_arbiter #(
    parameter int WORD_W      = 32,
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              ihit,
    output logic [WORD_W-1:0] iload,
    output logic              dhit,
    output logic [WORD_W-1:0] dload,
    output logic              bus_err,
    output logic              busy,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ram_ack
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
    localparam logic [SW-1:0] STREAK_ONE = SW'(1);
    localparam logic [TW-1:0] TMO_LIM    = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMO_ONE    = TW'(1);

    state_t            state_q, state_d;
    logic              own_d_q, own_d_d;     // 1 = data requester owns the port
    logic              op_w_q, op_w_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              ren_q, ren_d;
    logic              wen_q, wen_d;
    logic              busy_q, busy_d;
    logic              ihit_q, ihit_d;
    logic              dhit_q, dhit_d;
    logic              berr_q, berr_d;
    logic [WORD_W-1:0] iload_q, iload_d;
    logic [WORD_W-1:0] dload_q, dload_d;

    logic              dreq_s;
    logic              dgo_s;
    logic [TW-1:0]     tmo_inc_s;
    logic              fin_s;
    logic              fin_err_s;
    logic [WORD_W-1:0] fin_data_s;
    logic              hit_s;

    // Next-state and registered-output computation for the arbiter FSM
    always_comb begin
        state_d    = state_q;
        own_d_d    = own_d_q;
        op_w_d     = op_w_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        streak_d   = streak_q;
        tmo_d      = tmo_q;
        ren_d      = ren_q;
        wen_d      = wen_q;
        busy_d     = busy_q;
        ihit_d     = 1'b0;
        dhit_d     = 1'b0;
        berr_d     = 1'b0;
        iload_d    = iload_q;
        dload_d    = dload_q;
        fin_s      = 1'b0;
        fin_err_s  = 1'b0;
        fin_data_s = '0;
        hit_s      = 1'b0;
        dreq_s     = dWEN | dREN;
        dgo_s      = dreq_s & (~iREN | (streak_q < STREAK_MAX));
        tmo_inc_s  = tmo_q + TMO_ONE;

        case (state_q)
            S_IDLE: begin
                if (dgo_s) begin
                    own_d_d = 1'b1;
                    op_w_d  = dWEN;
                    addr_d  = daddr;
                    wdata_d = dstore;
                    ren_d   = ~dWEN;
                    wen_d   = dWEN;
                    tmo_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_GRANT;
                    if (!iREN) begin
                        streak_d = '0;
                    end else if (streak_q == STREAK_MAX) begin
                        streak_d = streak_q;
                    end else begin
                        streak_d = streak_q + STREAK_ONE;
                    end
                end else if (iREN) begin
                    own_d_d  = 1'b0;
                    op_w_d   = 1'b0;
                    addr_d   = iaddr;
                    wdata_d  = '0;
                    ren_d    = 1'b1;
                    wen_d    = 1'b0;
                    tmo_d    = '0;
                    busy_d   = 1'b1;
                    streak_d = '0;
                    state_d  = S_GRANT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                // An acknowledge in the expiry cycle still completes cleanly
                if (ram_ack) begin
                    fin_s      = 1'b1;
                    fin_err_s  = 1'b0;
                    fin_data_s = op_w_q ? '0 : ramload;
                end else if ((TIMEOUT != 0) && (tmo_inc_s == TMO_LIM)) begin
                    fin_s      = 1'b1;
                    fin_err_s  = 1'b1;
                    fin_data_s = '0;
                end else begin
                    tmo_d = tmo_inc_s;
                end
                if (fin_s) begin
                    state_d = S_RESP;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    if (own_d_q) begin
                        hit_s   = dreq_s;
                        dhit_d  = dreq_s;
                        dload_d = fin_data_s;
                    end else begin
                        hit_s   = iREN;
                        ihit_d  = iREN;
                        iload_d = fin_data_s;
                    end
                    berr_d = fin_err_s & hit_s;
                end else begin
                    state_d = S_GRANT;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                ren_d   = 1'b0;
                wen_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            own_d_q  <= 1'b0;
            op_w_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            streak_q <= '0;
            tmo_q    <= '0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            busy_q   <= 1'b0;
            ihit_q   <= 1'b0;
            dhit_q   <= 1'b0;
            berr_q   <= 1'b0;
            iload_q  <= '0;
            dload_q  <= '0;
        end else begin
            state_q  <= state_d;
            own_d_q  <= own_d_d;
            op_w_q   <= op_w_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            streak_q <= streak_d;
            tmo_q    <= tmo_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            busy_q   <= busy_d;
            ihit_q   <= ihit_d;
            dhit_q   <= dhit_d;
            berr_q   <= berr_d;
            iload_q  <= iload_d;
            dload_q  <= dload_d;
        end
    end

    assign ihit     = ihit_q;
    assign iload    = iload_q;
    assign dhit     = dhit_q;
    assign dload    = dload_q;
    assign bus_err  = berr_q;
    assign busy     = busy_q;
    assign ramREN   = ren_q;
    assign ramWEN   = wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = wdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level model of grant order, latency and results.
module tb_memory_arbiter;
    localparam int W    = 32;
    localparam int MAXD = 4;
    localparam int TMO  = 8;

    logic         CLK = 1'b0;
    logic         RST, iREN, dREN, dWEN, ram_ack;
    logic [W-1:0] iaddr, daddr, dstore, ramload;
    logic         ihit, dhit, bus_err, busy, ramREN, ramWEN;
    logic [W-1:0] iload, dload, ramaddr, ramstore;
    logic         nt_ihit, nt_dhit, nt_bus_err, nt_busy, nt_ramREN, nt_ramWEN;
    logic [W-1:0] nt_iload, nt_dload, nt_ramaddr, nt_ramstore;

    int checks = 0;
    int errors = 0;

    bit         i_pend, d_pend, d_rd, d_wr;
    logic [31:0] i_addr, d_addr, d_store;
    int          streak;
    logic [31:0] iload_m, dload_m;

    memory_arbiter #(.WORD_W(W), .MAX_DSTREAK(MAXD), .TIMEOUT(TMO)) u_dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .ihit(ihit), .iload(iload), .dhit(dhit),
        .dload(dload), .bus_err(bus_err), .busy(busy), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ram_ack(ram_ack)
    );

    memory_arbiter #(.WORD_W(W), .MAX_DSTREAK(MAXD), .TIMEOUT(0)) u_nt (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .ihit(nt_ihit), .iload(nt_iload), .dhit(nt_dhit),
        .dload(nt_dload), .bus_err(nt_bus_err), .busy(nt_busy), .ramREN(nt_ramREN),
        .ramWEN(nt_ramWEN), .ramaddr(nt_ramaddr), .ramstore(nt_ramstore),
        .ramload(ramload), .ram_ack(ram_ack)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive();
        iREN   = i_pend;
        iaddr  = i_addr;
        dREN   = d_pend && d_rd;
        dWEN   = d_pend && d_wr;
        daddr  = d_addr;
        dstore = d_store;
    endtask

    task automatic model_reset();
        streak  = 0;
        iload_m = 32'h0;
        dload_m = 32'h0;
    endtask

    // One arbitration round from IDLE: k = ack cycle (beyond TMO means never), wd = withdraw winner.
    task automatic run_txn(input int k, input bit wd, input logic [31:0] rl, output bit own_d);
        bit          ew, terr;
        int          len;
        logic [31:0] ea, edata;
        own_d = 1'b0;
        if (!i_pend && !d_pend) begin
            tick();
            chk("idle_busy", {31'h0, busy}, 32'h0);
            chk("idle_strobes", {30'h0, ramREN, ramWEN}, 32'h0);
        end else begin
            own_d = d_pend && (!i_pend || streak < MAXD);
            if (own_d) streak = i_pend ? ((streak < MAXD) ? streak + 1 : MAXD) : 0;
            else       streak = 0;
            ea    = own_d ? d_addr : i_addr;
            ew    = own_d && d_wr;
            len   = (k < TMO) ? k : TMO;
            terr  = (k > TMO);
            edata = (terr || ew) ? 32'h0 : rl;
            tick();
            if (wd) begin
                if (own_d) d_pend = 1'b0;
                else       i_pend = 1'b0;
                drive();
            end
            for (int c = 1; c <= len; c++) begin
                chk("grant_ren", {31'h0, ramREN}, {31'h0, !ew});
                chk("grant_wen", {31'h0, ramWEN}, {31'h0, ew});
                chk("grant_addr", ramaddr, ea);
                chk("grant_busy", {31'h0, busy}, 32'h1);
                if (ew) chk("grant_store", ramstore, d_store);
                if (c == k) begin
                    ram_ack = 1'b1;
                    ramload = rl;
                end
                tick();
                ram_ack = 1'b0;
                ramload = $urandom;
            end
            if (own_d) dload_m = edata;
            else       iload_m = edata;
            chk("resp_ihit", {31'h0, ihit}, {31'h0, !own_d && !wd});
            chk("resp_dhit", {31'h0, dhit}, {31'h0, own_d && !wd});
            chk("resp_bus_err", {31'h0, bus_err}, {31'h0, terr && !wd});
            chk("resp_iload", iload, iload_m);
            chk("resp_dload", dload, dload_m);
            chk("resp_strobes", {30'h0, ramREN, ramWEN}, 32'h0);
            chk("resp_busy", {31'h0, busy}, 32'h1);
            if (!wd) begin
                if (own_d) d_pend = 1'b0;
                else       i_pend = 1'b0;
                drive();
            end
            ram_ack = 1'($urandom_range(0, 1));
            tick();
            ram_ack = 1'b0;
            chk("idle_busy_after", {31'h0, busy}, 32'h0);
            chk("idle_hits_after", {30'h0, ihit, dhit}, 32'h0);
            chk("idle_iload_hold", iload, iload_m);
            chk("idle_dload_hold", dload, dload_m);
        end
    endtask

    initial begin : main
        bit o;
        int nd, first_i, last_o;
        RST = 1'b1; ram_ack = 1'b0; ramload = 32'h0;
        i_pend = 0; d_pend = 0; d_rd = 0; d_wr = 0;
        i_addr = 32'h0; d_addr = 32'h0; d_store = 32'h0;
        drive();
        model_reset();
        tick(); tick();
        chk("rst_hits", {29'h0, ihit, dhit, bus_err}, 32'h0);
        chk("rst_busy_strobes", {29'h0, busy, ramREN, ramWEN}, 32'h0);
        chk("rst_loads", iload | dload, 32'h0);
        chk("rst_ram_regs", ramaddr | ramstore, 32'h0);
        RST = 1'b0;

        // TIMEOUT=0 instance keeps its strobe up with no acknowledge
        d_pend = 1; d_rd = 1; d_wr = 0; d_addr = 32'h500; drive();
        tick();
        for (int c = 0; c < 30; c++) begin
            chk("nto_ren", {31'h0, nt_ramREN}, 32'h1);
            chk("nto_nohit", {30'h0, nt_dhit, nt_bus_err}, 32'h0);
            tick();
        end
        chk("nto_busy", {31'h0, nt_busy}, 32'h1);
        i_pend = 0; d_pend = 0; drive();
        RST = 1'b1; tick(); RST = 1'b0;
        model_reset();

        // Single fetch
        i_pend = 1; i_addr = 32'h40; drive();
        run_txn(1, 1'b0, 32'h8C220004, o);
        chk("fetch_owner", {31'h0, o}, 32'h0);

        // Simultaneous fetch and write: data first, then fetch
        i_pend = 1; i_addr = 32'h80;
        d_pend = 1; d_wr = 1; d_rd = 0; d_addr = 32'h100; d_store = 32'hDEAD; drive();
        run_txn(1, 1'b0, 32'h12345678, o);
        chk("simul_first_d", {31'h0, o}, 32'h1);
        run_txn(1, 1'b0, 32'h0BADF00D, o);
        chk("simul_then_i", {31'h0, o}, 32'h0);

        // Timeout on a data read, then ack coinciding with expiry on a read+write
        d_pend = 1; d_rd = 1; d_wr = 0; d_addr = 32'h204; drive();
        run_txn(20, 1'b0, 32'hFFFF0000, o);
        d_pend = 1; d_rd = 1; d_wr = 1; d_addr = 32'h208; d_store = 32'h55AA; drive();
        run_txn(TMO, 1'b0, 32'hCAFEBABE, o);

        // Withdrawn fetch completes silently
        i_pend = 1; i_addr = 32'h44; drive();
        run_txn(3, 1'b1, 32'h11112222, o);

        // Build a data streak, then reset in the middle of a grant
        i_pend = 1; i_addr = 32'h300;
        d_pend = 1; d_rd = 1; d_wr = 0; d_addr = 32'h400; drive();
        for (int n = 0; n < 2; n++) begin
            run_txn(1, 1'b0, $urandom, o);
            d_pend = 1; drive();
        end
        tick();
        chk("rstg_pre_ren", {31'h0, ramREN}, 32'h1);
        RST = 1'b1; tick(); RST = 1'b0;
        chk("rstg_strobes", {30'h0, ramREN, ramWEN}, 32'h0);
        chk("rstg_busy", {31'h0, busy}, 32'h0);
        chk("rstg_nohit", {30'h0, ihit, dhit}, 32'h0);
        model_reset();

        // Starvation: exactly MAXD data grants before the fetch, then data again
        nd = 0; first_i = 0; last_o = 0;
        for (int n = 0; n < 6; n++) begin
            run_txn(1, 1'b0, $urandom, o);
            if (!o) first_i = 1;
            else if (!first_i) nd++;
            last_o = int'(o);
            d_pend = 1; drive();
        end
        chk("starve_dcount", nd, MAXD);
        chk("starve_resume", last_o, 1);

        // Random traffic
        for (int n = 0; n < 200; n++) begin
            if (!i_pend && ($urandom_range(0, 1) == 1)) begin
                i_pend = 1; i_addr = $urandom;
            end
            if (!d_pend && ($urandom_range(0, 2) != 0)) begin
                int r;
                r = $urandom_range(1, 3);
                d_pend = 1; d_rd = (r != 2); d_wr = (r != 1);
                d_addr = $urandom; d_store = $urandom;
            end
            drive();
            run_txn($urandom_range(1, 10), ($urandom_range(0, 7) == 0), $urandom, o);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
